// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: defaults, FSM encoding
// and the packed-port slicing helper.
package regfile_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned NREGS_DEF  = 32;
    localparam int unsigned RF_BUS_W   = 256;
    localparam int unsigned RF_SLICE_W = 64;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

    // Returns field i (of width w) of a packed port bus, LSB-aligned.
    function automatic logic [RF_SLICE_W-1:0] rf_sel(
        input logic [RF_BUS_W-1:0] bus,
        input int unsigned         i,
        input int unsigned         w
    );
        logic [RF_BUS_W-1:0] w_shifted;
        w_shifted = bus >> (i * w);
        return RF_SLICE_W'(w_shifted);
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every entry once writing zero, then
// releases the register file into normal operation.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic          Clk,
    input  logic          RstN,
    output logic          Busy,
    output logic          ClrWe,
    output logic [AW-1:0] ClrAddr
);

    rf_state_e       r_state;
    rf_state_e       w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_nxt;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                w_cnt_nxt = r_cnt + AW'(1);
                if (r_cnt == AW'(NREGS - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        Busy    = 1'b0;
        ClrWe   = 1'b0;
        ClrAddr = r_cnt;
        if (r_state == ST_CLEAR) begin
            Busy  = 1'b1;
            ClrWe = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with optional bypass, optional
// hardwired zero entry and a post-reset clear sequence.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned AW       = $clog2(NREGS),
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                  Clk,
    input  logic                  RstN,
    input  logic                  En,
    input  logic                  We,
    input  logic [AW-1:0]         SelD,
    input  logic [XLEN-1:0]       DataD,
    input  logic [NREAD*AW-1:0]   SelRS,
    output logic [NREAD*XLEN-1:0] DataRS,
    output logic                  Busy
);

    logic            w_busy;
    logic            w_clr_we;
    logic [AW-1:0]   w_clr_addr;
    logic            w_user_we;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] r_mem [NREGS];

    regfile_clear_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_seq (
        .Clk     (Clk),
        .RstN    (RstN),
        .Busy    (w_busy),
        .ClrWe   (w_clr_we),
        .ClrAddr (w_clr_addr)
    );

    assign Busy = w_busy;

    // Clear sequencer owns the write port while busy; user writes are dropped.
    always_comb begin
        w_user_we = We && !((ZERO_REG != 0) && (SelD == '0));
        w_we      = w_user_we;
        w_waddr   = SelD;
        w_wdata   = DataD;
        if (w_clr_we) begin
            w_we    = 1'b1;
            w_waddr = w_clr_addr;
            w_wdata = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   w_sel;
        logic [XLEN-1:0] w_val;
        logic [XLEN-1:0] r_data;

        assign w_sel = AW'(rf_sel(RF_BUS_W'(SelRS), 32'(i), AW));

        // Zero entry beats bypass, bypass beats array contents.
        always_comb begin
            w_val = r_mem[w_sel];
            if (w_busy) begin
                w_val = '0;
            end else if ((ZERO_REG != 0) && (w_sel == '0)) begin
                w_val = '0;
            end else if ((BYPASS != 0) && We && (w_sel == SelD)) begin
                w_val = DataD;
            end
        end

        always_ff @(posedge Clk or negedge RstN) begin
            if (!RstN) begin
                r_data <= '0;
            end else if (En) begin
                r_data <= w_val;
            end
        end

        assign DataRS[i*XLEN +: XLEN] = r_data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: bypass/no-bypass 32x32 instances and a
// 4-port 16x64 instance.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, we;
    logic [4:0]  sel_d;
    logic [31:0] data_d;
    logic [9:0]  sel_rs;
    logic [63:0] rs_a, rs_b;
    logic        busy_a, busy_b;

    logic         en_c, we_c;
    logic [3:0]   sel_d_c;
    logic [63:0]  data_d_c;
    logic [15:0]  sel_rs_c;
    logic [255:0] rs_c;
    logic         busy_c;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_m [32];
    logic [31:0] exp_a [2];
    logic [31:0] exp_b [2];
    logic [63:0] vals_c [16];

    typedef struct {
        logic        we;
        logic [4:0]  sd;
        logic [31:0] dd;
        logic        en;
        logic [4:0]  r0, r1;
        logic [31:0] a0, a1, b0, b1;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1)) dut_a (
        .Clk(clk), .RstN(rst_n), .En(en), .We(we), .SelD(sel_d), .DataD(data_d),
        .SelRS(sel_rs), .DataRS(rs_a), .Busy(busy_a)
    );

    regfile_mp #(.BYPASS(0)) dut_b (
        .Clk(clk), .RstN(rst_n), .En(en), .We(we), .SelD(sel_d), .DataD(data_d),
        .SelRS(sel_rs), .DataRS(rs_b), .Busy(busy_b)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(4)) dut_c (
        .Clk(clk), .RstN(rst_n), .En(en_c), .We(we_c), .SelD(sel_d_c), .DataD(data_d_c),
        .SelRS(sel_rs_c), .DataRS(rs_c), .Busy(busy_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference read/write rules in RUN: zero entry, then bypass (A only), then storage.
    task automatic model_step();
        for (int p = 0; p < 2; p++) begin
            logic [4:0] s;
            s = sel_rs[p*5 +: 5];
            if (en) begin
                if (s == 5'd0) begin
                    exp_a[p] = 32'h0;
                    exp_b[p] = 32'h0;
                end else begin
                    exp_b[p] = mem_m[s];
                    exp_a[p] = (we && sel_d == s) ? data_d : mem_m[s];
                end
            end
        end
        if (we && sel_d != 5'd0) mem_m[sel_d] = data_d;
    endtask

    task automatic count_busy(input string tag, output int na, output int nc);
        int n;
        n = 0; na = 0; nc = 0;
        while ((na == 0 || nc == 0) && n < 100) begin
            tick();
            n++;
            if (!busy_a && na == 0) na = n;
            if (!busy_c && nc == 0) nc = n;
        end
        chk({tag, "_busy_len32"}, 64'(na), 64'd32);
        chk({tag, "_busy_len16"}, 64'(nc), 64'd16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nc;

        tbl[0]  = '{1'b1, 5'd3,  32'h12345678, 1'b1, 5'd5,  5'd3,  32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd3,  32'h0,        32'h12345678, 32'h0,        32'h12345678};
        tbl[2]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b1, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF};
        tbl[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd7,  32'h12345678, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  32'h12345678, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5};
        tbl[7]  = '{1'b1, 5'd3,  32'h0BADF00D, 1'b0, 5'd3,  5'd3,  32'h12345678, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5};
        tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D};
        tbl[9]  = '{1'b1, 5'd31, 32'hCAFEBABE, 1'b1, 5'd31, 5'd0,  32'hCAFEBABE, 32'h0,        32'h0,        32'h0};
        tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd31, 32'h0,        32'hCAFEBABE, 32'h0,        32'hCAFEBABE};

        rst_n = 1'b0; en = 1'b1; we = 1'b1; sel_d = 5'd5; data_d = 32'hDEADBEEF;
        sel_rs = {5'd0, 5'd5};
        en_c = 1'b0; we_c = 1'b0; sel_d_c = 4'd0; data_d_c = 64'h0; sel_rs_c = 16'h0;
        tick();
        tick();
        chk("rst_busy_a", 64'(busy_a), 64'd1);
        chk("rst_rs_a", rs_a, 64'h0);
        chk("rst_busy_c", 64'(busy_c), 64'd1);
        chk("rst_rs_c", rs_c[63:0], 64'h0);

        // Write to 5 held throughout the clear sequence.
        rst_n = 1'b1;
        count_busy("init", na, nc);
        chk("clear_rs_a", rs_a, 64'h0);
        chk("clear_rs_b", rs_b, 64'h0);
        tick();
        chk("first_wr_bypass", 64'(rs_a[31:0]), 64'hDEADBEEF);
        chk("first_wr_old", 64'(rs_b[31:0]), 64'h0);
        we = 1'b0;
        tick();
        chk("first_wr_landed", 64'(rs_b[31:0]), 64'hDEADBEEF);

        for (int r = 0; r < 32; r++) mem_m[r] = 32'h0;
        mem_m[5] = 32'hDEADBEEF;
        exp_a[0] = 32'hDEADBEEF; exp_a[1] = 32'h0;
        exp_b[0] = 32'hDEADBEEF; exp_b[1] = 32'h0;

        for (int v = 0; v < 11; v++) begin
            we = tbl[v].we; sel_d = tbl[v].sd; data_d = tbl[v].dd; en = tbl[v].en;
            sel_rs = {tbl[v].r1, tbl[v].r0};
            model_step();
            tick();
            chk($sformatf("tbl%0d_a0", v), 64'(rs_a[31:0]),  64'(tbl[v].a0));
            chk($sformatf("tbl%0d_a1", v), 64'(rs_a[63:32]), 64'(tbl[v].a1));
            chk($sformatf("tbl%0d_b0", v), 64'(rs_b[31:0]),  64'(tbl[v].b0));
            chk($sformatf("tbl%0d_b1", v), 64'(rs_b[63:32]), 64'(tbl[v].b1));
        end

        for (int c = 0; c < 300; c++) begin
            we     = 1'($urandom);
            en     = ($urandom_range(0, 3) != 0);
            sel_d  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            data_d = $urandom;
            sel_rs[4:0] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            sel_rs[9:5] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            model_step();
            tick();
            chk("rnd_a0", 64'(rs_a[31:0]),  64'(exp_a[0]));
            chk("rnd_a1", 64'(rs_a[63:32]), 64'(exp_a[1]));
            chk("rnd_b0", 64'(rs_b[31:0]),  64'(exp_b[0]));
            chk("rnd_b1", 64'(rs_b[63:32]), 64'(exp_b[1]));
        end

        // Asynchronous reset mid-RUN with nonzero outputs.
        we = 1'b1; sel_d = 5'd9; data_d = 32'h11111111; en = 1'b0;
        tick();
        we = 1'b0; en = 1'b1; sel_rs = {5'd9, 5'd9};
        tick();
        chk("pre_rst_rd", 64'(rs_b[31:0]), 64'h11111111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rs_a", rs_a, 64'h0);
        chk("async_rst_busy_a", 64'(busy_a), 64'd1);
        #1;
        rst_n = 1'b1;
        we = 1'b1; sel_d = 5'd9; data_d = 32'h22222222;
        for (int k = 0; k < 10; k++) tick();
        chk("midclr_busy", 64'(busy_a), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midclr_rst_busy", 64'(busy_a), 64'd1);
        chk("midclr_rst_rs", rs_b, 64'h0);
        tick();
        rst_n = 1'b1;
        count_busy("restart", na, nc);
        we = 1'b0;
        for (int r = 0; r < 32; r += 2) begin
            sel_rs = {5'(r + 1), 5'(r)};
            tick();
            chk($sformatf("zero_a_r%0d", r),     64'(rs_a[31:0]),  64'h0);
            chk($sformatf("zero_a_r%0d", r + 1), 64'(rs_a[63:32]), 64'h0);
            chk($sformatf("zero_b_r%0d", r),     64'(rs_b[31:0]),  64'h0);
            chk($sformatf("zero_b_r%0d", r + 1), 64'(rs_b[63:32]), 64'h0);
        end

        // Four-port wide instance: fill 1..15, read four distinct entries per cycle.
        vals_c[0] = 64'h0;
        for (int r = 1; r < 16; r++) begin
            vals_c[r] = {$urandom, $urandom};
            we_c = 1'b1; sel_d_c = 4'(r); data_d_c = vals_c[r];
            tick();
        end
        we_c = 1'b0; en_c = 1'b1;
        for (int k = 0; k < 16; k++) begin
            for (int p = 0; p < 4; p++) sel_rs_c[p*4 +: 4] = 4'((k + 5 * p) % 16);
            tick();
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("c_k%0d_p%0d", k, p), rs_c[p*64 +: 64], vals_c[(k + 5 * p) % 16]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
